// File: rtl/div_issue_pkg.sv
// div_issue_pkg: funct3 codes, bus types, handshake levels and FSM encodings for the divide issue controller.
package div_issue_pkg;
  localparam logic [2:0] INST_DIV = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;
  typedef logic [31:0] reg_bus_t;
  typedef logic [4:0] reg_addr_t;
  localparam reg_bus_t ZERO_WORD = 32'h0;
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_RESULT_READY = 1'b1;
  localparam logic RST_ASYNC_ENABLE = 1'b0;
  typedef enum logic [1:0] {
    DIVI_IDLE = 2'd0,
    DIVI_BUSY = 2'd1,
    DIVI_ABORT = 2'd2
  } divi_state_e;
endpackage

// File: rtl/div_issue_watchdog.sv
// div_watchdog: cycle counter with clear/enable that flags TIMEOUT_CYCLES-1 as terminal count.
module div_watchdog
  import div_issue_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (rst == RST_ASYNC_ENABLE) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign tc = cnt == TC_VAL;
endmodule

// File: rtl/div_issue.sv
// div_issue: EX-stage requester for the iterative divider; latches operands, holds start, stalls the pipe, writes back.
module div_issue
  import div_issue_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        flush_i,
  output logic        div_start_o,
  output logic [31:0] div_dividend_o,
  output logic [31:0] div_divisor_o,
  output logic [2:0]  div_op_o,
  output logic [4:0]  div_reg_waddr_o,
  input  logic [31:0] div_result_i,
  input  logic        div_ready_i,
  input  logic        div_busy_i,
  output logic        hold_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic        err_o
);
  divi_state_e state, state_nxt;
  reg_bus_t dividend_q, divisor_q;
  logic [2:0] op_q;
  reg_addr_t rd_q;
  logic req, accept, done, hold, tc;
  assign req = inst_valid_i & op_i[2] & ~flush_i;
  always_comb begin
    state_nxt = state;
    accept = 1'b0;
    done = 1'b0;
    hold = 1'b0;
    err_o = 1'b0;
    div_start_o = 1'b0;
    case (state)
      DIVI_IDLE: begin
        hold = req;
        accept = req & ~div_busy_i;
        state_nxt = accept ? DIVI_BUSY : DIVI_IDLE;
      end
      DIVI_BUSY:
        if (flush_i) state_nxt = div_busy_i ? DIVI_ABORT : DIVI_IDLE;
        else if (div_ready_i == DIV_RESULT_READY) begin
          done = 1'b1;
          state_nxt = DIVI_IDLE;
        end else if (tc) begin
          err_o = 1'b1;
          hold = 1'b1;
          state_nxt = DIVI_ABORT;
        end else begin
          div_start_o = DIV_START;
          hold = 1'b1;
        end
      DIVI_ABORT: begin
        hold = req;
        state_nxt = div_busy_i ? DIVI_ABORT : DIVI_IDLE;
      end
      default: state_nxt = DIVI_IDLE;
    endcase
  end
  // The hold path is combinational from inputs, so mask it while reset is asserted.
  assign hold_o = hold & (rst != RST_ASYNC_ENABLE);
  assign reg_we_o = done & (|rd_q);
  assign reg_waddr_o = done ? rd_q : '0;
  assign reg_wdata_o = done ? div_result_i : ZERO_WORD;
  assign div_dividend_o = dividend_q;
  assign div_divisor_o = divisor_q;
  assign div_op_o = op_q;
  assign div_reg_waddr_o = rd_q;
  always_ff @(posedge clk or negedge rst)
    if (rst == RST_ASYNC_ENABLE) begin
      state <= DIVI_IDLE;
      dividend_q <= ZERO_WORD;
      divisor_q <= ZERO_WORD;
      op_q <= '0;
      rd_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dividend_q <= rs1_data_i;
        divisor_q <= rs2_data_i;
        op_q <= op_i;
        rd_q <= rd_addr_i;
      end
    end
  div_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_wd (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .en (state == DIVI_BUSY),
    .tc (tc)
  );
endmodule

// File: tb/tb_div_issue.sv
// tb_div_issue: directed checks of div_issue with the divider handshake driven by the bench.
module tb_div_issue;
  logic clk = 1'b0, rst;
  logic inst_valid_i, flush_i, div_ready_i, div_busy_i;
  logic [2:0] op_i;
  logic [31:0] rs1_data_i, rs2_data_i, div_result_i;
  logic [4:0] rd_addr_i;
  logic div_start_o, hold_o, reg_we_o, err_o;
  logic [31:0] div_dividend_o, div_divisor_o, reg_wdata_o;
  logic [2:0] div_op_o;
  logic [4:0] div_reg_waddr_o, reg_waddr_o;
  int tests = 0, fails = 0;
  logic err_seen;
  always #5 clk = ~clk;
  div_issue dut (
    .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i), .op_i(op_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rd_addr_i(rd_addr_i),
    .flush_i(flush_i), .div_start_o(div_start_o), .div_dividend_o(div_dividend_o),
    .div_divisor_o(div_divisor_o), .div_op_o(div_op_o), .div_reg_waddr_o(div_reg_waddr_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i), .div_busy_i(div_busy_i),
    .hold_o(hold_o), .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o),
    .reg_wdata_o(reg_wdata_o), .err_o(err_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    inst_valid_i = 1'b1;
    op_i = op;
    rs1_data_i = a;
    rs2_data_i = b;
    rd_addr_i = rd;
  endtask
  initial begin
    rst = 1'b0;
    flush_i = 1'b0;
    div_ready_i = 1'b0;
    div_busy_i = 1'b0;
    div_result_i = 32'h0;
    issue(3'b100, 32'd100, 32'd7, 5'd5);
    @(negedge clk);
    #1;
    chk("rst_hold", hold_o, 0);
    chk("rst_start", div_start_o, 0);
    chk("rst_we", reg_we_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_dividend", div_dividend_o, 0);
    chk("rst_rd", div_reg_waddr_o, 0);
    // DIV 100/7 -> 14 into x5
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("div_acc_hold", hold_o, 1);
    chk("div_acc_start", div_start_o, 0);
    tick();
    div_busy_i = 1'b1;
    #1;
    chk("div_start", div_start_o, 1);
    chk("div_hold", hold_o, 1);
    chk("div_dividend", div_dividend_o, 100);
    chk("div_divisor", div_divisor_o, 7);
    chk("div_op", div_op_o, 3'b100);
    chk("div_rd", div_reg_waddr_o, 5);
    tick();
    tick();
    #1;
    chk("div_start_mid", div_start_o, 1);
    div_ready_i = 1'b1;
    div_busy_i = 1'b0;
    div_result_i = 32'd14;
    #1;
    chk("div_rdy_start", div_start_o, 0);
    chk("div_we", reg_we_o, 1);
    chk("div_waddr", reg_waddr_o, 5);
    chk("div_wdata", reg_wdata_o, 14);
    chk("div_rdy_hold", hold_o, 0);
    tick();
    div_ready_i = 1'b0;
    inst_valid_i = 1'b0;
    #1;
    chk("div_post_we", reg_we_o, 0);
    chk("div_post_start", div_start_o, 0);
    chk("div_post_hold", hold_o, 0);
    // REM -7 % 2 -> -1 into x3
    issue(3'b110, 32'hFFFFFFF9, 32'd2, 5'd3);
    tick();
    div_busy_i = 1'b1;
    #1;
    chk("rem_op", div_op_o, 3'b110);
    tick();
    div_ready_i = 1'b1;
    div_busy_i = 1'b0;
    div_result_i = 32'hFFFFFFFF;
    #1;
    chk("rem_we", reg_we_o, 1);
    chk("rem_waddr", reg_waddr_o, 3);
    chk("rem_wdata", reg_wdata_o, 32'hFFFFFFFF);
    tick();
    div_ready_i = 1'b0;
    // DIVU 5/0: divider answers 2 cycles after accept
    issue(3'b101, 32'd5, 32'd0, 5'd4);
    #1;
    chk("dz_acc_hold", hold_o, 1);
    tick();
    div_busy_i = 1'b1;
    #1;
    chk("dz_start", div_start_o, 1);
    tick();
    div_ready_i = 1'b1;
    div_busy_i = 1'b0;
    div_result_i = 32'hFFFFFFFF;
    #1;
    chk("dz_we", reg_we_o, 1);
    chk("dz_waddr", reg_waddr_o, 4);
    chk("dz_wdata", reg_wdata_o, 32'hFFFFFFFF);
    tick();
    div_ready_i = 1'b0;
    // DIVU to x0: completes without write
    issue(3'b101, 32'hFFFFFFFF, 32'd1, 5'd0);
    tick();
    div_busy_i = 1'b1;
    tick();
    div_ready_i = 1'b1;
    div_busy_i = 1'b0;
    div_result_i = 32'hFFFFFFFF;
    #1;
    chk("x0_we", reg_we_o, 0);
    chk("x0_hold", hold_o, 0);
    chk("x0_start", div_start_o, 0);
    tick();
    div_ready_i = 1'b0;
    // Non-divide funct3 is ignored
    issue(3'b000, 32'd1, 32'd1, 5'd1);
    #1;
    chk("nondiv_hold", hold_o, 0);
    tick();
    #1;
    chk("nondiv_start", div_start_o, 0);
    // Flush 10 cycles into BUSY, then held off in ABORT
    issue(3'b100, 32'd9, 32'd3, 5'd7);
    tick();
    div_busy_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    flush_i = 1'b1;
    inst_valid_i = 1'b0;
    #1;
    chk("fl_start", div_start_o, 0);
    chk("fl_hold", hold_o, 0);
    chk("fl_we", reg_we_o, 0);
    tick();
    flush_i = 1'b0;
    issue(3'b100, 32'd20, 32'd4, 5'd6);
    #1;
    chk("ab_hold", hold_o, 1);
    chk("ab_start", div_start_o, 0);
    tick();
    #1;
    chk("ab_hold2", hold_o, 1);
    chk("ab_start2", div_start_o, 0);
    div_busy_i = 1'b0;
    tick();
    #1;
    chk("ab_idle_hold", hold_o, 1);
    tick();
    div_busy_i = 1'b1;
    #1;
    chk("ab_new_start", div_start_o, 1);
    chk("ab_new_dividend", div_dividend_o, 20);
    tick();
    div_ready_i = 1'b1;
    div_busy_i = 1'b0;
    div_result_i = 32'd5;
    #1;
    chk("ab_new_wdata", reg_wdata_o, 5);
    chk("ab_new_waddr", reg_waddr_o, 6);
    chk("ab_new_we", reg_we_o, 1);
    tick();
    div_ready_i = 1'b0;
    // Flush coincident with ready
    issue(3'b111, 32'd8, 32'd3, 5'd2);
    tick();
    div_busy_i = 1'b1;
    tick();
    div_ready_i = 1'b1;
    div_busy_i = 1'b0;
    flush_i = 1'b1;
    div_result_i = 32'd123;
    inst_valid_i = 1'b0;
    #1;
    chk("flr_we", reg_we_o, 0);
    chk("flr_start", div_start_o, 0);
    chk("flr_hold", hold_o, 0);
    tick();
    div_ready_i = 1'b0;
    flush_i = 1'b0;
    #1;
    chk("flr_norelaunch", div_start_o, 0);
    // Timeout with a divider that never answers
    issue(3'b100, 32'd1, 32'd1, 5'd1);
    tick();
    div_busy_i = 1'b1;
    #1;
    chk("to_idle_accept", div_start_o, 1);
    err_seen = 1'b0;
    for (int i = 0; i < 63; i++) begin
      err_seen |= err_o;
      tick();
    end
    #1;
    chk("to_early_err", err_seen, 0);
    chk("to_err", err_o, 1);
    chk("to_start", div_start_o, 0);
    chk("to_we", reg_we_o, 0);
    tick();
    inst_valid_i = 1'b0;
    #1;
    chk("to_ab_err", err_o, 0);
    chk("to_ab_start", div_start_o, 0);
    chk("to_ab_hold", hold_o, 0);
    tick();
    div_busy_i = 1'b0;
    tick();
    // Async reset mid-BUSY
    issue(3'b100, 32'd50, 32'd5, 5'd9);
    tick();
    div_busy_i = 1'b1;
    #1;
    chk("ar_start_pre", div_start_o, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_start", div_start_o, 0);
    chk("ar_hold", hold_o, 0);
    chk("ar_dividend", div_dividend_o, 0);
    chk("ar_rd", div_reg_waddr_o, 0);
    @(negedge clk);
    rst = 1'b1;
    inst_valid_i = 1'b0;
    div_busy_i = 1'b0;
    #1;
    chk("ar_post_start", div_start_o, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
